// File: rtl/wide_add_pkg.sv
// Shared types and defaults for the multi-cycle wide adder.
// Imported by the top level so state encoding stays in one place.
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_CHUNK_WIDTH = 8;
    localparam int DEF_NUM_CHUNKS  = 4;

endpackage

// File: rtl/cla_slice.sv
// Combinational CHUNK_WIDTH-bit carry-lookahead adder slice.
// Each carry is a flat sum of generate terms gated by propagate runs.
module cla_slice #(
    parameter int CHUNK_WIDTH = 8
) (
    input  logic [CHUNK_WIDTH-1:0] a,
    input  logic [CHUNK_WIDTH-1:0] b,
    input  logic                   cin,
    output logic [CHUNK_WIDTH-1:0] sum,
    output logic                   cout
);

    logic [CHUNK_WIDTH-1:0] g;
    logic [CHUNK_WIDTH-1:0] p;
    logic [CHUNK_WIDTH:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic run;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            c[i+1] = g[i];
            run    = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (run & g[j]);
                run    = run & p[j];
            end
            c[i+1] = c[i+1] | (run & cin);
        end
    end

    assign sum  = p ^ c[CHUNK_WIDTH-1:0];
    assign cout = c[CHUNK_WIDTH];

endmodule

// File: rtl/wide_add_seq.sv
// Wide add/subtract that walks one CLA slice across the operand,
// least-significant chunk first, carrying between cycles.
import wide_add_pkg::*;

module wide_add_seq #(
    parameter int CHUNK_WIDTH = DEF_CHUNK_WIDTH,
    parameter int NUM_CHUNKS  = DEF_NUM_CHUNKS,
    parameter int W           = CHUNK_WIDTH * NUM_CHUNKS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         out_ovf
);

    localparam int IDXW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    state_t state_q, state_d;

    logic [IDXW-1:0] idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [CHUNK_WIDTH-1:0] sl_a, sl_b, sl_sum;
    logic                   sl_cout;
    logic                   last;

    cla_slice #(
        .CHUNK_WIDTH(CHUNK_WIDTH)
    ) u_cla (
        .a   (sl_a),
        .b   (sl_b),
        .cin (carry_q),
        .sum (sl_sum),
        .cout(sl_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign last = (idx_q == IDXW'(NUM_CHUNKS - 1));
    assign sl_a = a_q[int'(idx_q)*CHUNK_WIDTH +: CHUNK_WIDTH];
    assign sl_b = b_q[int'(idx_q)*CHUNK_WIDTH +: CHUNK_WIDTH];

    always_comb begin
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE && in_valid) begin
            a_d     = in_a;
            b_d     = in_sub ? ~in_b : in_b;
            carry_d = in_sub ? 1'b1 : in_cin;
            idx_d   = '0;
        end else if (state_q == RUN) begin
            res_d[int'(idx_q)*CHUNK_WIDTH +: CHUNK_WIDTH] = sl_sum;
            carry_d = sl_cout;
            idx_d   = last ? '0 : idx_q + IDXW'(1);
            // Publish only on the final slice so outputs hold through DONE
            if (last) begin
                sum_d  = res_d;
                cout_d = sl_cout;
                ovf_d  = (a_q[W-1] == b_q[W-1]) && (res_d[W-1] != a_q[W-1]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
    assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq: vector table plus handshake corner cases.
// Also exercises a single-chunk build.
module tb_wide_add_seq;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        in_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    logic       s_in_valid = 1'b0;
    logic       s_in_ready;
    logic [7:0] s_in_a = '0;
    logic [7:0] s_in_b = '0;
    logic       s_in_cin = 1'b0;
    logic       s_in_sub = 1'b0;
    logic       s_out_valid;
    logic       s_out_ready = 1'b0;
    logic [7:0] s_out_sum;
    logic       s_out_cout;
    logic       s_out_ovf;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t tbl[8];

    always #5 clk = ~clk;

    wide_add_seq #(.CHUNK_WIDTH(8), .NUM_CHUNKS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf)
    );

    wide_add_seq #(.CHUNK_WIDTH(8), .NUM_CHUNKS(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (s_in_valid),
        .in_ready (s_in_ready),
        .in_a     (s_in_a),
        .in_b     (s_in_b),
        .in_cin   (s_in_cin),
        .in_sub   (s_in_sub),
        .out_valid(s_out_valid),
        .out_ready(s_out_ready),
        .out_sum  (s_out_sum),
        .out_cout (s_out_cout),
        .out_ovf  (s_out_ovf)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic sub,
                                input logic [31:0] sum, input logic cout,
                                input logic ovf);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.sum = sum; v.cout = cout; v.ovf = ovf;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_a     = v.a;
        in_b     = v.b;
        in_cin   = v.cin;
        in_sub   = v.sub;
        in_valid = 1'b1;
    endtask

    task automatic issue(input vec_t v);
        int n;
        @(negedge clk);
        drive(v);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got=0 want=1");
        end
        @(posedge clk);
        sb.push_back(v);
        #1 in_valid = 1'b0;
    endtask

    task automatic compare_front(input string nm);
        vec_t v;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb_empty got=0 want=1", nm);
            return;
        end
        v = sb.pop_front();
        chk({nm, "_sum"}, 64'(out_sum), 64'(v.sum));
        chk({nm, "_cout"}, 64'(out_cout), 64'(v.cout));
        chk({nm, "_ovf"}, 64'(out_ovf), 64'(v.ovf));
    endtask

    task automatic collect(input string nm);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 20);
        chk({nm, "_lat"}, 64'(n), 64'd4);
        @(negedge clk);
        compare_front(nm);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        int   n;
        vec_t x, y, z;

        tbl[0] = mk(32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0);
        tbl[1] = mk(32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1);
        tbl[2] = mk(32'h00000005, 32'h00000007, 1, 1, 32'hFFFFFFFE, 0, 0);
        tbl[3] = mk(32'h12345678, 32'h11111111, 0, 0, 32'h23456789, 0, 0);
        tbl[4] = mk(32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 1);
        tbl[5] = mk(32'h00FF00FF, 32'h0001FF01, 1, 0, 32'h01010001, 0, 0);
        tbl[6] = mk(32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1, 1);
        tbl[7] = mk(32'h00000007, 32'h00000007, 0, 1, 32'h00000000, 1, 0);

        #12 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_cout", 64'(out_cout), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);

        for (int i = 0; i < 8; i++) begin
            issue(tbl[i]);
            collect($sformatf("vec%0d", i));
        end

        // Backpressure: result must hold while new operands wait
        x = mk(32'h0000FFFF, 32'h00000102, 0, 0, 32'h00010101, 0, 0);
        y = mk(32'hA5A5A5A5, 32'h5A5A5A5A, 1, 0, 32'h00000000, 1, 0);
        issue(x);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 20);
        chk("bp_lat", 64'(n), 64'd4);
        @(negedge clk);
        drive(y);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_sum", 64'(out_sum), 64'(x.sum));
        end
        @(negedge clk);
        compare_front("bp_x");
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("bp_idle_ready", 64'(in_ready), 64'd1);
        chk("bp_idle_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        sb.push_back(y);
        #1 in_valid = 1'b0;
        chk("bp_y_taken", 64'(in_ready), 64'd0);
        collect("bp_y");

        // Reset two slices into a run; nothing from it may appear
        z = mk(32'hDEADBEEF, 32'h01010101, 0, 0, 32'hDFAEBFF0, 0, 0);
        issue(z);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_sum", 64'(out_sum), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        issue(tbl[3]);
        collect("post_rst");

        // Single-chunk build: RUN lasts exactly one cycle
        @(negedge clk);
        chk("s_in_ready", 64'(s_in_ready), 64'd1);
        s_in_a     = 8'hFF;
        s_in_b     = 8'h01;
        s_in_cin   = 1'b1;
        s_in_sub   = 1'b0;
        s_in_valid = 1'b1;
        @(posedge clk);
        #1 s_in_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!s_out_valid && n < 20);
        chk("s_lat", 64'(n), 64'd1);
        chk("s_sum", 64'(s_out_sum), 64'h01);
        chk("s_cout", 64'(s_out_cout), 64'd1);
        chk("s_ovf", 64'(s_out_ovf), 64'd0);
        @(negedge clk);
        s_out_ready = 1'b1;
        @(posedge clk);
        #1 s_out_ready = 1'b0;
        chk("s_back_idle", 64'(s_in_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
